dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Initiator side of the data-memory interface. Sits between the MEM pipeline stage and the byte-addressed 64-bit data RAM.
- Accepts one load or store request at a time and sequences the RAM enables.
- Performs read-modify-write for sub-doubleword stores, extracts and sign- or zero-extends load data, and returns a single response carrying any access error.

Parameters:
- MEM_BYTES, 1024, RAM size in bytes; an access is out of range when addr+8 > MEM_BYTES.
- SEXT_DEFAULT, 1, reset value of the internal signed flag; no functional effect after the first accepted request.

Ports:
- clk_i  in  1  clock; all state on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  controller idle; a request is accepted when req_valid_i and req_ready_o are both high.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = doubleword.
- req_signed_i  in  1  sign-extend load data.
- req_addr_i  in  64  byte address.
- req_wdata_i  in  64  store data, right-aligned.
- resp_valid_o  out  1  response valid; held until accepted.
- resp_ready_i  in  1  consumer accepts the response.
- resp_rdata_o  out  64  extended load data; 0 for stores and errors.
- resp_error_o  out  1  access fault.
- mem_read_en_o  out  1  RAM read enable.
- mem_write_en_o  out  1  RAM write enable; level-sensitive at the RAM.
- mem_addr_o  out  64  RAM byte address.
- mem_write_data_o  out  64  RAM write data; little-endian, byte 0 at mem_addr_o.
- mem_read_data_i  in  64  combinational RAM read data.
- mem_error_i  in  1  RAM address fault.

Behaviour:
- Reset:
  - State goes to IDLE.
  - req_ready_o=1; all other outputs 0.
  - Reset during any state aborts the operation; mem_write_en_o is low from the next edge and no response is produced.
- Output timing: all mem_* outputs are registered. mem_addr_o and mem_write_data_o are stable for the whole cycle in which mem_write_en_o=1. mem_write_en_o is never high for more than one cycle per request.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE: req_ready_o=1. On accept, latch the request, then:
    - range fail (addr+8 > MEM_BYTES) -> RESP with error;
    - load -> RD;
    - store with size 3 -> WR;
    - store with size 0-2 -> RD (read-modify-write).
  - RD: mem_read_en_o=1, mem_addr_o=latched addr.
    - mem_error_i=1 -> RESP with error; no write is issued.
    - Load -> capture and extend data, go to RESP.
    - RMW store -> merge the low 2^size bytes of wdata into the read data, go to WR.
  - WR: mem_write_en_o=1 for exactly this cycle.
    - mem_error_i=1 -> error flagged.
    - Always go to RESP.
  - RESP: resp_valid_o=1. Stay until resp_ready_i=1, then go to IDLE. req_ready_o rises the cycle after the handshake.
- Latency, accept edge to resp_valid_o high:
  - load: 2 cycles;
  - doubleword store: 2 cycles;
  - sub-doubleword store: 3 cycles;
  - range error: 1 cycle.
- Load extension: take the low 2^size bytes of mem_read_data_i. If req_signed_i=1, replicate the top bit of that field; otherwise zero-fill. Size 3 passes data through unchanged.
- Simultaneous events: a new req_valid_i arriving during RESP with resp_ready_i=1 is not accepted until the following IDLE cycle. There is no back-to-back overlap.
- Boundary: addr = MEM_BYTES-8 is legal; addr = MEM_BYTES-7 is a range error.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: in IDLE, an address not aligned to 2^size (addr & (2^size-1) != 0) goes directly to RESP with resp_error_o=1. No RAM enable is asserted.
- Undefined: misaligned addresses are accessed normally, subject only to the range check.

Test Plan:
- Signed byte load: RAM[0x10..0x17]=0x00000000000000F0, load size 0, signed=1, addr 0x10 -> resp_rdata_o=0xFFFFFFFFFFFFFFF0, error 0, resp_valid_o 2 cycles after accept. Same load with signed=0 -> 0x00000000000000F0.
- Doubleword store then load at addr 0x20: store wdata 0x1122334455667788 -> exactly one mem_write_en_o pulse. Subsequent load size 3 returns 0x1122334455667788.
- Halfword RMW store: RAM[0x40]=0xAAAAAAAAAAAAAAAA, store size 1, wdata 0xBEEF -> write data 0xAAAAAAAAAAAABEEF, response 3 cycles after accept.
- Range error: load at addr 1017 with MEM_BYTES=1024 -> resp_error_o=1 after 1 cycle, mem_read_en_o never asserted. Addr 1016 succeeds.
- Backpressure and reset: hold resp_ready_i=0 for 5 cycles -> resp_valid_o and resp_rdata_o stay stable, req_ready_o=0. Assert rst_i while in WR -> no second write pulse, all outputs 0 next cycle.
- Misalign trap: with DMEM_MISALIGN_TRAP_EN defined, word load at 0x102 -> error, no RAM enable asserted. Without the macro -> normal data returned.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator: one load/store at a time, RMW for sub-doubleword stores, load extension.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned accesses into immediate error responses.
module dmem_access_ctrl #(
  parameter int   MEM_BYTES    = 1024,
  parameter logic SEXT_DEFAULT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_error_o,
  output logic        mem_read_en_o,
  output logic        mem_write_en_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_write_data_o,
  input  logic [63:0] mem_read_data_i,
  input  logic        mem_error_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [63:0] wdata_q, wdata_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        range_err;
  logic        req_fault;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                         input logic sg);
    logic [63:0] r;
    case (sz)
      2'd0:    r = {{56{sg & d[7]}},  d[7:0]};
      2'd1:    r = {{48{sg & d[15]}}, d[15:0]};
      2'd2:    r = {{32{sg & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] rd, input logic [63:0] wd,
                                        input logic [1:0] sz);
    logic [63:0] r;
    case (sz)
      2'd0:    r = {rd[63:8],  wd[7:0]};
      2'd1:    r = {rd[63:16], wd[15:0]};
      2'd2:    r = {rd[63:32], wd[31:0]};
      default: r = wd;
    endcase
    return r;
  endfunction

  // 65-bit sum so addresses near 2^64 cannot wrap into range
  assign range_err = ({1'b0, req_addr_i} + 65'd8) > 65'(MEM_BYTES);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic [63:0] align_mask;
  assign align_mask = (64'd1 << req_size_i) - 64'd1;
  assign req_fault  = range_err | ((req_addr_i & align_mask) != 64'd0);
`else
  assign req_fault  = range_err;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    wdata_d     = wdata_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d       = req_we_i;
          size_d     = req_size_i;
          sext_d     = req_signed_i;
          wdata_d    = req_wdata_i;
          mem_addr_d = req_addr_i;
          rdata_d    = 64'd0;
          err_d      = 1'b0;
          if (req_fault) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_we_i && req_size_i == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata_i;
            state_d     = WR;
          end else begin
            mem_re_d = 1'b1;
            state_d  = RD;
          end
        end
      end
      RD: begin
        mem_re_d = 1'b0;
        if (mem_error_i) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (!we_q) begin
          rdata_d = extend(mem_read_data_i, size_q, sext_q);
          state_d = RESP;
        end else begin
          mem_wdata_d = merge(mem_read_data_i, wdata_q, size_q);
          mem_we_d    = 1'b1;
          state_d     = WR;
        end
      end
      WR: begin
        mem_we_d = 1'b0;
        if (mem_error_i) err_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready_i) begin
          rdata_d = 64'd0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      sext_q      <= SEXT_DEFAULT;
      wdata_q     <= 64'd0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      rdata_q     <= 64'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      wdata_q     <= wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o      = (state_q == IDLE);
  assign resp_valid_o     = (state_q == RESP);
  assign resp_rdata_o     = rdata_q;
  assign resp_error_o     = err_q;
  assign mem_read_en_o    = mem_re_q;
  assign mem_write_en_o   = mem_we_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_write_data_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboarded bench for dmem_access_ctrl against a 1 KiB byte RAM model.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic        req_ready, resp_valid, resp_error, mem_re, mem_we, mem_err;
  logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        err_rd = 1'b0, err_wr = 1'b0;

  int total = 0, bad = 0;
  int wr_cnt = 0, rd_cnt = 0;
  logic [63:0] last_wdata = 64'd0;
  logic [7:0] ram [0:1023];

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dmem_access_ctrl #(.MEM_BYTES(1024), .SEXT_DEFAULT(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_error_o(resp_error),
    .mem_read_en_o(mem_re), .mem_write_en_o(mem_we), .mem_addr_o(mem_addr),
    .mem_write_data_o(mem_wdata), .mem_read_data_i(mem_rdata), .mem_error_i(mem_err)
  );

  assign mem_err = (err_rd & mem_re) | (err_wr & mem_we);

  always_comb begin
    mem_rdata = 64'd0;
    for (int i = 0; i < 8; i++) begin
      logic [9:0] idx;
      idx = mem_addr[9:0] + 10'(i);
      mem_rdata[8*i +: 8] = ram[idx];
    end
  end

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) ram[10'(mem_addr[9:0] + 10'(i))] <= mem_wdata[8*i +: 8];
      last_wdata <= mem_wdata;
      wr_cnt     <= wr_cnt + 1;
    end
    if (mem_re) rd_cnt <= rd_cnt + 1;
  end

  // One request/response; latency counts edges from the accept edge (inclusive) to resp_valid.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg, input logic [63:0] a,
                       input logic [63:0] wd, input int hold, output logic [63:0] rd,
                       output logic er, output int lat, output logic stable);
    @(negedge clk);
    wr_cnt = 0; rd_cnt = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rd = resp_rdata; er = resp_error; stable = 1'b1;
    if (lat >= 20) return;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_rdata !== rd || resp_error !== er || req_ready) stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    if ({req_ready, resp_valid, resp_error, mem_re, mem_we} !== 5'b10000 ||
        resp_rdata !== 64'd0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin
      bad++;
      $display("FAIL reset: ready/valid/err/re/we=%b rdata=%h addr=%h wdata=%h, want 10000 and zeros",
               {req_ready, resp_valid, resp_error, mem_re, mem_we}, resp_rdata, mem_addr, mem_wdata);
    end
    total++;
  endtask

  task automatic test_dw_store;
    logic [63:0] rd; logic er, st; int lat; exp_t e;
    logic [63:0] addrs [5] = '{64'h10, 64'h40, 64'h50, 64'h3F8, 64'h100};
    logic [63:0] vals  [5] = '{64'h00000000000000F0, 64'hAAAAAAAAAAAAAAAA, 64'h7F00000080008001,
                               64'h0807060504030201, 64'h8786858483828180};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{64'd0, 1'b0, 2});
      issue(1'b1, 2'd3, 1'b0, addrs[i], vals[i], 0, rd, er, lat, st);
      e = exp_q.pop_front();
      if (rd !== e.rdata || er !== e.err || lat !== e.lat || wr_cnt !== 1 || last_wdata !== vals[i]) begin
        bad++;
        $display("FAIL dw_store[%0d]: rdata=%h err=%b lat=%0d wr=%0d wdata=%h want %h %b %0d 1 %h",
                 i, rd, er, lat, wr_cnt, last_wdata, e.rdata, e.err, e.lat, vals[i]);
      end
      total++;
    end
  endtask

  task automatic test_loads;
    logic [63:0] rd; logic er, st; int lat; exp_t e;
    logic [1:0]  szs  [9] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd1};
    logic        sgs  [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [63:0] adrs [9] = '{64'h10, 64'h10, 64'h50, 64'h50, 64'h50, 64'h50, 64'h3F8, 64'h50, 64'h50};
    logic [63:0] exps [9] = '{64'hFFFFFFFFFFFFFFF0, 64'h00000000000000F0, 64'hFFFFFFFFFFFF8001,
                              64'hFFFFFFFF80008001, 64'h0000000080008001, 64'h0000000000000001,
                              64'h0807060504030201, 64'h7F00000080008001, 64'h0000000000008001};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back('{exps[i], 1'b0, 2});
      issue(1'b0, szs[i], sgs[i], adrs[i], 64'd0, 0, rd, er, lat, st);
      e = exp_q.pop_front();
      if (rd !== e.rdata || er !== e.err || lat !== e.lat || wr_cnt !== 0 || rd_cnt !== 1) begin
        bad++;
        $display("FAIL load[%0d]: rdata=%h err=%b lat=%0d wr=%0d rd=%0d want %h %b %0d 0 1",
                 i, rd, er, lat, wr_cnt, rd_cnt, e.rdata, e.err, e.lat);
      end
      total++;
    end
  endtask

  task automatic test_rmw;
    logic [63:0] rd; logic er, st; int lat; exp_t e;
    logic [1:0]  szs  [3] = '{2'd1, 2'd0, 2'd2};
    logic [63:0] wds  [3] = '{64'h123456789ABCBEEF, 64'hFFFFFFFFFFFFFF5A, 64'h00000000CAFEF00D};
    logic [63:0] exps [3] = '{64'hAAAAAAAAAAAABEEF, 64'hAAAAAAAAAAAABE5A, 64'hAAAAAAAACAFEF00D};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{64'd0, 1'b0, 3});
      issue(1'b1, szs[i], 1'b0, 64'h40, wds[i], 0, rd, er, lat, st);
      e = exp_q.pop_front();
      if (rd !== e.rdata || er !== e.err || lat !== e.lat || wr_cnt !== 1 || last_wdata !== exps[i]) begin
        bad++;
        $display("FAIL rmw[%0d]: rdata=%h err=%b lat=%0d wr=%0d wdata=%h want %h %b %0d 1 %h",
                 i, rd, er, lat, wr_cnt, last_wdata, e.rdata, e.err, e.lat, exps[i]);
      end
      total++;
    end
  endtask

  task automatic test_range;
    logic [63:0] rd; logic er, st; int lat; exp_t e;
    logic [63:0] adrs [3] = '{64'd1017, 64'd1016, 64'hFFFFFFFFFFFFFFFC};
    logic        errs [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] exps [3] = '{64'd0, 64'h0807060504030201, 64'd0};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{exps[i], errs[i], errs[i] ? 1 : 2});
      issue(1'b0, 2'd3, 1'b0, adrs[i], 64'd0, 0, rd, er, lat, st);
      e = exp_q.pop_front();
      if (rd !== e.rdata || er !== e.err || lat !== e.lat || rd_cnt !== (errs[i] ? 0 : 1)) begin
        bad++;
        $display("FAIL range[%0d]: rdata=%h err=%b lat=%0d rd=%0d want %h %b %0d %0d",
                 i, rd, er, lat, rd_cnt, e.rdata, e.err, e.lat, errs[i] ? 0 : 1);
      end
      total++;
    end
  endtask

  task automatic test_mem_error;
    logic [63:0] rd; logic er, st; int lat; exp_t e;
    err_rd = 1'b1;
    exp_q.push_back('{64'd0, 1'b1, 2});
    issue(1'b1, 2'd0, 1'b0, 64'h60, 64'h55, 0, rd, er, lat, st);
    err_rd = 1'b0;
    e = exp_q.pop_front();
    if (rd !== e.rdata || er !== e.err || lat !== e.lat || wr_cnt !== 0) begin
      bad++;
      $display("FAIL rd_error: rdata=%h err=%b lat=%0d wr=%0d want %h %b %0d 0", rd, er, lat, wr_cnt,
               e.rdata, e.err, e.lat);
    end
    total++;
    err_wr = 1'b1;
    exp_q.push_back('{64'd0, 1'b1, 2});
    issue(1'b1, 2'd3, 1'b0, 64'h60, 64'h99, 0, rd, er, lat, st);
    err_wr = 1'b0;
    e = exp_q.pop_front();
    if (rd !== e.rdata || er !== e.err || lat !== e.lat || wr_cnt !== 1) begin
      bad++;
      $display("FAIL wr_error: rdata=%h err=%b lat=%0d wr=%0d want %h %b %0d 1", rd, er, lat, wr_cnt,
               e.rdata, e.err, e.lat);
    end
    total++;
  endtask

  task automatic test_backpressure;
    logic [63:0] rd; logic er, st; int lat; exp_t e;
    exp_q.push_back('{64'hFFFFFFFFFFFFFFF0, 1'b0, 2});
    issue(1'b0, 2'd0, 1'b1, 64'h10, 64'd0, 5, rd, er, lat, st);
    e = exp_q.pop_front();
    if (rd !== e.rdata || er !== e.err || lat !== e.lat || st !== 1'b1 || req_ready !== 1'b1 ||
        resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL backpressure: rdata=%h err=%b lat=%0d stable=%b ready=%b valid=%b want %h %b %0d 1 1 0",
               rd, er, lat, st, req_ready, resp_valid, e.rdata, e.err, e.lat);
    end
    total++;
  endtask

  task automatic test_misalign;
    logic [63:0] rd; logic er, st; int lat; exp_t e;
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_q.push_back('{64'd0, 1'b1, 1});
`else
    exp_q.push_back('{64'h0000000085848382, 1'b0, 2});
`endif
    issue(1'b0, 2'd2, 1'b0, 64'h102, 64'd0, 0, rd, er, lat, st);
    e = exp_q.pop_front();
    if (rd !== e.rdata || er !== e.err || lat !== e.lat || rd_cnt !== (e.err ? 0 : 1)) begin
      bad++;
      $display("FAIL misalign: rdata=%h err=%b lat=%0d rd=%0d want %h %b %0d", rd, er, lat, rd_cnt,
               e.rdata, e.err, e.lat);
    end
    total++;
  endtask

  task automatic test_reset_in_wr;
    int n;
    @(negedge clk);
    wr_cnt = 0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 64'h80; req_wdata = 64'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!mem_we && n < 10) begin
      @(posedge clk); #1; n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if ({req_ready, resp_valid, resp_error, mem_re, mem_we} !== 5'b10000 || resp_rdata !== 64'd0 ||
        mem_addr !== 64'd0 || mem_wdata !== 64'd0 || n != 1) begin
      bad++;
      $display("FAIL reset_in_wr: flags=%b rdata=%h addr=%h wdata=%h wait=%0d want 10000 zeros wait=1",
               {req_ready, resp_valid, resp_error, mem_re, mem_we}, resp_rdata, mem_addr, mem_wdata, n);
    end
    total++;
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) n++;
    end
    if (wr_cnt !== 1 || n != 0) begin
      bad++;
      $display("FAIL reset_in_wr_after: writes=%0d resp_cycles=%0d want 1 0", wr_cnt, n);
    end
    total++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_dw_store();
    test_loads();
    test_rmw();
    test_range();
    test_mem_error();
    test_backpressure();
    test_misalign();
    test_reset_in_wr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
